ofdm_symbol_scheduler: RTL
==========================

# ofdm_symbol_scheduler

Sequences the constellation modulator over whole OFDM symbols. For each subcarrier slot of each symbol it classifies the slot as null, pilot or data, pulls BITS-wide codes from the upstream bitstream for data slots, and generates pilot codes from a per-symbol polarity LFSR. It sits between the bit source and the modulator/IFFT input, and emits a tagged, backpressured slot stream.

## Interface
- N_FFT, 64: subcarriers per symbol; power of two.
- ACTIVE_HALF, 26: used subcarriers each side of DC.
- PILOT_STEP, 14: pilot spacing in |signed index|.
- PILOT_OFF, 7: pilot offset; pilot when |s| mod PILOT_STEP == PILOT_OFF.
- BITS, 2: bits per constellation code.

- clk  in  1  clock; all state on rising edge.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  pulse; begins a frame when in IDLE.
- num_symbols  in  8  symbols per frame; sampled on accepted start.
- bit_data  in  BITS  upstream constellation code.
- bit_valid  in  1  bit_data valid.
- bit_ready  out  1  code consumed this cycle when bit_valid && bit_ready.
- map_code  out  BITS  code to modulator (0 when null).
- map_kind  out  2  00 null, 01 data, 10 pilot.
- map_index  out  log2(N_FFT)  subcarrier index k.
- map_sof  out  1  slot k==0.
- map_last  out  1  slot k==N_FFT-1.
- map_valid  out  1  output slot valid.
- map_ready  in  1  downstream accepts slot.
- busy  out  1  state != IDLE.
- done  out  1  one-cycle pulse at frame end.

## Operation
- States: IDLE, RUN, DONE.
- IDLE: start && num_symbols != 0 -> RUN; latch num_symbols, slot index k=0, symbol count=0, LFSR=7'h7F. start with num_symbols==0 ignored; start outside IDLE ignored.
- Classification of k: s = k for k < N_FFT/2, else k - N_FFT. Null if k==0 or |s| > ACTIVE_HALF. Pilot if not null and |s| mod PILOT_STEP == PILOT_OFF. Otherwise data. Defaults give 12 null, 4 pilot (k=7,21,43,57), 48 data.
- Output register is free when !map_valid || map_ready.
- In RUN, slot k issues when register free and: null or pilot slot (always), or data slot with bit_valid. Issuing loads map_* and sets map_valid; k increments.
- bit_ready = RUN && data slot && register free. Data slot with bit_valid low: no issue, k holds (bubble); not an error.
- Pilot code: lfsr[6]==0 -> 0 (1+1j); lfsr[6]==1 -> 2^BITS-1 (-1-1j).
- LFSR x^7+x^4+1 Fibonacci, shift left, new bit0 = lfsr[6]^lfsr[3]; advances once when slot N_FFT-1 issues.
- k wraps N_FFT-1 -> 0 on issue; symbol count increments. Issue of slot N_FFT-1 of the last symbol -> DONE.
- DONE: waits until final slot accepted (register free); then done=1 for one cycle, -> IDLE.
- map_valid clears when register free and nothing issues.

## Timing
- Reset values: bit_ready 0, map_valid 0, map_code 0, map_kind 0, map_index 0, map_sof 0, map_last 0, busy 0, done 0; state IDLE; LFSR 7'h7F.
- start sampled cycle t; busy=1 from t+1; slot 0 visible with map_valid=1 at t+2.
- Throughput one slot/cycle with map_ready=1 and bit_valid=1; N_FFT cycles per symbol.
- Output held stable while map_valid && !map_ready; bit_ready=0 during that stall.
- done asserts in the cycle after the last slot is accepted; busy drops with done.
- Reset asserted mid-frame: all outputs clear immediately; a code presented with bit_ready high in that cycle is not consumed.
- start arriving in the DONE cycle is ignored.

## Test plan
- num_symbols=1, map_ready=1, bit_valid=1 always -> 64 slots k=0..63, 12 null/4 pilot/48 data, 48 bit handshakes, pilots code 3 (lfsr[6]=1), map_last at k=63, done 2 cycles after slot 63 issues.
- num_symbols=3 -> pilot polarity follows LFSR sequence across symbols; map_sof every 64 slots; exactly 144 codes consumed.
- bit_valid low for 5 cycles at k=10 -> map_valid drops, k holds at 10, resumes with the correct code, no slot skipped or duplicated.
- map_ready low for 4 cycles mid-symbol -> map_* stable, bit_ready=0, no code consumed; resumes without loss.
- rst asserted at k=30 of symbol 2 -> outputs zero immediately; new start with num_symbols=1 restarts at k=0 with LFSR 7'h7F.
- start with num_symbols=0, and start while busy -> ignored; busy and map_valid unaffected.

Source files
------------

// File: rtl/ofdm_symbol_scheduler_if.sv
// Slot-stream bundle: upstream code handshake in, tagged modulator slot stream out.
interface ofdm_symbol_scheduler_if #(
    parameter int unsigned BITS  = 2,
    parameter int unsigned IDX_W = 6
);
    logic [BITS-1:0]  bit_data;
    logic             bit_valid;
    logic             bit_ready;
    logic [BITS-1:0]  map_code;
    logic [1:0]       map_kind;
    logic [IDX_W-1:0] map_index;
    logic             map_sof;
    logic             map_last;
    logic             map_valid;
    logic             map_ready;

    // Scheduler side: consumes codes, produces slots.
    modport master (
        input  bit_data, bit_valid, map_ready,
        output bit_ready, map_code, map_kind, map_index, map_sof, map_last, map_valid
    );

    // Environment side: bit source and modulator.
    modport slave (
        output bit_data, bit_valid, map_ready,
        input  bit_ready, map_code, map_kind, map_index, map_sof, map_last, map_valid
    );
endinterface

// File: rtl/ofdm_symbol_scheduler.sv
// Walks every subcarrier slot of every OFDM symbol, tags it null/data/pilot,
// pulls codes for data slots and derives pilot polarity from a per-symbol LFSR.
module ofdm_symbol_scheduler #(
    parameter int unsigned N_FFT       = 64,
    parameter int unsigned ACTIVE_HALF = 26,
    parameter int unsigned PILOT_STEP  = 14,
    parameter int unsigned PILOT_OFF   = 7,
    parameter int unsigned BITS        = 2
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start_i,
    input  logic [7:0]             num_symbols_i,
    output logic                   busy_o,
    output logic                   done_o,
    ofdm_symbol_scheduler_if.master bus
);
    localparam int unsigned IDX_W = $clog2(N_FFT);
    localparam int unsigned SW    = IDX_W + 1;

    localparam logic [1:0]      KIND_NULL  = 2'b00;
    localparam logic [1:0]      KIND_DATA  = 2'b01;
    localparam logic [1:0]      KIND_PILOT = 2'b10;
    localparam logic [BITS-1:0] CODE_NEG   = '1;
    localparam logic [6:0]      LFSR_SEED  = 7'h7F;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    state_e           state_q, state_d;
    logic [IDX_W-1:0] k_q, k_d;
    logic [7:0]       sym_cnt_q, sym_cnt_d;
    logic [7:0]       nsym_q, nsym_d;
    logic [6:0]       lfsr_q, lfsr_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic [BITS-1:0]  map_code_q, map_code_d;
    logic [1:0]       map_kind_q, map_kind_d;
    logic [IDX_W-1:0] map_index_q, map_index_d;
    logic             map_sof_q, map_sof_d;
    logic             map_last_q, map_last_d;
    logic             map_valid_q, map_valid_d;

    logic [SW-1:0]    s_abs_c;
    logic             null_c;
    logic             pilot_c;
    logic             data_c;
    logic             free_c;
    logic             issue_c;
    logic             last_slot_c;
    logic             last_sym_c;
    logic             start_ok_c;
    logic             bit_ready_c;

    // Slot classification from |signed subcarrier index|.
    always_comb begin
        s_abs_c = k_q[IDX_W-1] ? (SW'(N_FFT) - SW'(k_q)) : SW'(k_q);
        null_c  = (k_q == '0) || (s_abs_c > SW'(ACTIVE_HALF));
        pilot_c = !null_c && ((s_abs_c % SW'(PILOT_STEP)) == SW'(PILOT_OFF));
        data_c  = !null_c && !pilot_c;
    end

    // Handshake qualifiers shared by the FSM and the datapath.
    always_comb begin
        free_c      = !map_valid_q || bus.map_ready;
        bit_ready_c = (state_q == ST_RUN) && data_c && free_c;
        issue_c     = (state_q == ST_RUN) && free_c && (!data_c || bus.bit_valid);
        last_slot_c = (k_q == IDX_W'(N_FFT - 1));
        last_sym_c  = (sym_cnt_q == (nsym_q - 8'd1));
        start_ok_c  = (state_q == ST_IDLE) && start_i && (num_symbols_i != 8'd0);
    end

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; DONE holds through the done pulse so a start there is ignored.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (start_ok_c) state_d = ST_RUN;
            ST_RUN:  if (issue_c && last_slot_c && last_sym_c) state_d = ST_DONE;
            ST_DONE: if (done_q) state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // Datapath and registered-output next values.
    always_comb begin
        k_d         = k_q;
        sym_cnt_d   = sym_cnt_q;
        nsym_d      = nsym_q;
        lfsr_d      = lfsr_q;
        busy_d      = busy_q;
        done_d      = 1'b0;
        map_code_d  = map_code_q;
        map_kind_d  = map_kind_q;
        map_index_d = map_index_q;
        map_sof_d   = map_sof_q;
        map_last_d  = map_last_q;
        map_valid_d = map_valid_q;

        if (start_ok_c) begin
            nsym_d    = num_symbols_i;
            k_d       = '0;
            sym_cnt_d = 8'd0;
            lfsr_d    = LFSR_SEED;
            busy_d    = 1'b1;
        end

        if (issue_c) begin
            map_valid_d = 1'b1;
            map_index_d = k_q;
            map_sof_d   = (k_q == '0);
            map_last_d  = last_slot_c;
            if (data_c) begin
                map_kind_d = KIND_DATA;
                map_code_d = bus.bit_data;
            end else if (pilot_c) begin
                map_kind_d = KIND_PILOT;
                map_code_d = lfsr_q[6] ? CODE_NEG : '0;
            end else begin
                map_kind_d = KIND_NULL;
                map_code_d = '0;
            end
            k_d = k_q + IDX_W'(1);
            if (last_slot_c) begin
                sym_cnt_d = sym_cnt_q + 8'd1;
                lfsr_d    = {lfsr_q[5:0], lfsr_q[6] ^ lfsr_q[3]};
            end
        end else if (free_c) begin
            map_valid_d = 1'b0;
        end

        if ((state_q == ST_DONE) && !done_q && free_c) begin
            done_d = 1'b1;
            busy_d = 1'b0;
        end
    end

    // Datapath and output registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            k_q         <= '0;
            sym_cnt_q   <= 8'd0;
            nsym_q      <= 8'd0;
            lfsr_q      <= LFSR_SEED;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            map_code_q  <= '0;
            map_kind_q  <= KIND_NULL;
            map_index_q <= '0;
            map_sof_q   <= 1'b0;
            map_last_q  <= 1'b0;
            map_valid_q <= 1'b0;
        end else begin
            k_q         <= k_d;
            sym_cnt_q   <= sym_cnt_d;
            nsym_q      <= nsym_d;
            lfsr_q      <= lfsr_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            map_code_q  <= map_code_d;
            map_kind_q  <= map_kind_d;
            map_index_q <= map_index_d;
            map_sof_q   <= map_sof_d;
            map_last_q  <= map_last_d;
            map_valid_q <= map_valid_d;
        end
    end

    assign bus.bit_ready = bit_ready_c;
    assign bus.map_code  = map_code_q;
    assign bus.map_kind  = map_kind_q;
    assign bus.map_index = map_index_q;
    assign bus.map_sof   = map_sof_q;
    assign bus.map_last  = map_last_q;
    assign bus.map_valid = map_valid_q;
    assign busy_o        = busy_q;
    assign done_o        = done_q;
endmodule
